dut_port_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single write/read method port pair of `dut` between up to four requesters. Each requester issues one-bit read or write commands to a 3-bit address over a valid/ready handshake. The arbiter serialises them onto `write_*`/`read_*` and, when the target method is ready, fires exactly one enable pulse. It returns one response per command, tagged with the requester index. It sits between testbench/system agents and `dut`, in place of direct drive of the method ports.

---
 rtl/dut_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_dut_port_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_port_arbiter.sv
// Round-robin arbiter that serialises up to four requesters onto the dut write/read method ports.
// Optional macro ARB_TIMEOUT_EN: abort a command whose method stays not-ready for TIMEOUT cycles.
module dut_port_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_write,
    input  logic [3*NREQ-1:0] req_addr,
    input  logic [NREQ-1:0]   req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_id,
    output logic              rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [2:0]        write_address,
    output logic              write_data,
    output logic              write_en,
    input  logic              write_rdy,
    output logic [2:0]        read_address,
    output logic              read_en,
    input  logic              read_data,
    input  logic              read_rdy,
    output logic [1:0]        state_dbg
);

    // Handshakes: a request transfers in the IDLE cycle where req_valid[i] & req_ready[i];
    // a response transfers on the edge where rsp_valid & rsp_ready; the method enable is
    // the single-cycle transfer to dut and is only raised while its rdy is high.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [2:0]  NREQ3        = 3'(NREQ);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [1:0]  rr_ptr;
    logic [1:0]  grant;
    logic        grant_vld;
    logic        sel_write;
    logic [2:0]  sel_addr;
    logic        sel_data;
    logic        cmd_write;
    logic [2:0]  cmd_addr;
    logic        cmd_data;
    logic [1:0]  cmd_id;
    logic        rsp_data_q;
    logic        rdy_sel;
    logic        fire;
    logic        abort;
    logic [2:0]  ptr_next;

    // Search upward from rr_ptr, wrapping modulo NREQ, for the first valid requester.
    always_comb begin
        logic [2:0] sum;
        logic       cand;
        grant     = 2'd0;
        grant_vld = 1'b0;
        sum       = 3'd0;
        cand      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + 3'(k);
            if (sum >= NREQ3) sum = sum - NREQ3;
            cand = 1'b0;
            for (int j = 0; j < NREQ; j++) begin
                if (sum == 3'(j)) cand = req_valid[j];
            end
            if (!grant_vld && cand) begin
                grant_vld = 1'b1;
                grant     = sum[1:0];
            end
        end
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = 3'd0;
        sel_data  = 1'b0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant == 2'(k)) begin
                sel_write = req_write[k];
                sel_addr  = req_addr[3*k +: 3];
                sel_data  = req_data[k];
            end
            req_ready[k] = (state == IDLE) && grant_vld && (grant == 2'(k));
        end
    end

    always_comb begin
        ptr_next = {1'b0, cmd_id} + 3'd1;
        if (ptr_next >= NREQ3) ptr_next = 3'd0;
    end

    assign rdy_sel = cmd_write ? write_rdy : read_rdy;
    assign fire    = (state == ISSUE) && rdy_sel;

    always_comb begin
        state_next = state;
        write_en   = 1'b0;
        read_en    = 1'b0;
        case (state)
            IDLE:    if (grant_vld) state_next = ISSUE;
            ISSUE: begin
                write_en = cmd_write & write_rdy;
                read_en  = ~cmd_write & read_rdy;
                if (fire || abort) state_next = RESP;
            end
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            rr_ptr     <= 2'd0;
            cmd_write  <= 1'b0;
            cmd_addr   <= 3'd0;
            cmd_data   <= 1'b0;
            cmd_id     <= 2'd0;
            rsp_data_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (grant_vld) begin
                    cmd_write <= sel_write;
                    cmd_addr  <= sel_addr;
                    cmd_data  <= sel_data;
                    cmd_id    <= grant;
                end
                ISSUE: begin
                    if (fire) rsp_data_q <= cmd_write ? 1'b0 : read_data;
                    else if (abort) rsp_data_q <= 1'b0;
                end
                RESP: if (rsp_ready) rr_ptr <= ptr_next[1:0];
                default: ;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        err_q;

    // A rdy arriving on the abort cycle wins because fire takes priority over abort.
    assign abort = (state == ISSUE) && !rdy_sel && (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt <= 16'd0;
            err_q    <= 1'b0;
        end else if (state != ISSUE) begin
            wait_cnt <= 16'd0;
        end else begin
            if (!rdy_sel) wait_cnt <= wait_cnt + 16'd1;
            if (fire) err_q <= 1'b0;
            else if (abort) err_q <= 1'b1;
        end
    end

    assign rsp_err = err_q;
`else
    logic unused_timeout;
    assign abort          = 1'b0;
    assign rsp_err        = 1'b0;
    assign unused_timeout = ^TIMEOUT_LAST;
`endif

    assign rsp_valid     = (state == RESP);
    assign rsp_id        = cmd_id;
    assign rsp_data      = rsp_data_q;
    assign busy          = (state != IDLE);
    assign write_address = cmd_addr;
    assign write_data    = cmd_data;
    assign read_address  = cmd_addr;
    assign state_dbg     = state;

endmodule

// File: tb/tb_dut_port_arbiter.sv
// Bench for dut_port_arbiter: directed scenarios plus randomized traffic against a
// round-robin / memory reference model; a small memory stands in for dut.
module tb_dut_port_arbiter;

    localparam int NREQ      = 2;
    localparam int TIMEOUT   = 8;
    localparam int RAND_CMDS = 150;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid, req_write, req_data, req_ready;
    logic [2:0] r_addr [2];
    logic [5:0] req_addr;
    logic       rsp_valid, rsp_ready, rsp_data, rsp_err, busy;
    logic [1:0] rsp_id, state_dbg;
    logic [2:0] write_address, read_address;
    logic       write_data, write_en, write_rdy, read_en, read_data, read_rdy;

    logic [7:0] dut_mem = 8'h00;
    logic [7:0] ref_mem;
    logic [3:0] exp_q[$];
    int         model_ptr;
    int         n_cmp = 0;
    int         n_fail = 0;

    assign req_addr  = {r_addr[1], r_addr[0]};
    assign read_data = dut_mem[read_address];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write_en) dut_mem[write_address] <= write_data;
    end

    dut_port_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) u_dut (
        .CLK(clk), .RST_N(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .write_address(write_address), .write_data(write_data),
        .write_en(write_en), .write_rdy(write_rdy),
        .read_address(read_address), .read_en(read_en),
        .read_data(read_data), .read_rdy(read_rdy),
        .state_dbg(state_dbg)
    );

    task automatic idle_inputs();
        req_valid = 2'b00; req_write = 2'b00; req_data = 2'b00;
        r_addr[0] = 3'd0;  r_addr[1] = 3'd0;
        rsp_ready = 1'b1;  write_rdy = 1'b1;  read_rdy = 1'b1;
    endtask

    task automatic set_req(input logic id, input logic w, input logic [2:0] a, input logic d);
        req_valid[id] = 1'b1;
        req_write[id] = w;
        r_addr[id]    = a;
        req_data[id]  = d;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy} !== 8'd0) begin
            n_fail++; $display("FAIL reset_rsp: got %b required 0", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy});
        end
        n_cmp++;
        if ({write_en, read_en, write_address, write_data, read_address, state_dbg} !== 13'd0) begin
            n_fail++; $display("FAIL reset_ports: got %b required 0", {write_en, read_en, write_address, write_data, read_address, state_dbg});
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int we_cnt;
        we_cnt = 0;
        set_req(1'b0, 1'b1, 3'd4, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL wr_accept: got %b required 01", req_ready); end
        @(posedge clk); #1 req_valid = 2'b00;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            if (write_en === 1'b1) we_cnt++;
            n_cmp++;
            if (c == 1 && {write_en, write_address, write_data} !== {1'b1, 3'd4, 1'b1}) begin
                n_fail++; $display("FAIL wr_enable: got %b required 11001", {write_en, write_address, write_data});
            end
            if (c == 2 && {rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL wr_rsp: got %b required 10000", {rsp_valid, rsp_id, rsp_data, rsp_err});
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (we_cnt != 1) begin n_fail++; $display("FAIL wr_pulse_count: got %0d required 1", we_cnt); end
        set_req(1'b0, 1'b0, 3'd4, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rd_accept: got %b required 01", req_ready); end
        @(posedge clk); #1 req_valid = 2'b00;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (c == 1 && {read_en, read_address, rsp_valid} !== {1'b1, 3'd4, 1'b0}) begin
                n_fail++; $display("FAIL rd_enable: got %b required 11000", {read_en, read_address, rsp_valid});
            end
            if (c == 2 && {rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd0, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL rd_rsp: got %b required 10010", {rsp_valid, rsp_id, rsp_data, rsp_err});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_round_robin();
        int grants, resps;
        logic drop;
        apply_reset();
        grants = 0; resps = 0;
        set_req(1'b0, 1'b0, 3'd1, 1'b0);
        set_req(1'b1, 1'b0, 3'd2, 1'b0);
        for (int cyc = 0; cyc < 30 && (grants < 4 || resps < 4); cyc++) begin
            drop = 1'b0;
            @(negedge clk);
            if (req_ready !== 2'b00) begin
                n_cmp++;
                if (req_ready !== ((grants % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_fail++; $display("FAIL rr_grant%0d: got %b required %0d", grants, req_ready, grants % 2);
                end
                grants++;
                drop = (grants == 4);
            end
            if (rsp_valid && rsp_ready) begin
                n_cmp++;
                if (rsp_id !== 2'(resps % 2)) begin
                    n_fail++; $display("FAIL rr_rsp_id%0d: got %0d required %0d", resps, rsp_id, resps % 2);
                end
                resps++;
            end
            @(posedge clk); #1;
            if (drop) req_valid = 2'b00;
        end
        n_cmp++;
        if (grants != 4 || resps != 4) begin
            n_fail++; $display("FAIL rr_count: got %0d grants %0d rsps required 4/4", grants, resps);
        end
    endtask

    task automatic test_backpressure();
        int we_cnt;
        we_cnt = 0;
        write_rdy = 1'b0; rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 3'd3, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_accept: got %b required 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        set_req(1'b1, 1'b0, 3'd3, 1'b0);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (write_en === 1'b1) we_cnt++;
            if (c <= 10) begin
                n_cmp++;
                if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_no_grant c%0d: got %b required 00", c, req_ready); end
            end
            if (c <= 5) begin
                n_cmp++;
                if (write_en !== 1'b0) begin n_fail++; $display("FAIL bp_stall c%0d: got %b required 0", c, write_en); end
            end
            if (c == 6) begin
                n_cmp++;
                if ({write_en, write_address, write_data} !== {1'b1, 3'd3, 1'b1}) begin
                    n_fail++; $display("FAIL bp_enable: got %b required 10111", {write_en, write_address, write_data});
                end
            end
            if (c >= 7 && c <= 10) begin
                n_cmp++;
                if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
                    n_fail++; $display("FAIL bp_rsp_hold c%0d: got %b required 10000", c, {rsp_valid, rsp_id, rsp_data, rsp_err});
                end
            end
            if (c == 11) begin
                n_cmp++;
                if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_next_grant: got %b required 10", req_ready); end
            end
            if (c == 12) begin
                n_cmp++;
                if ({read_en, read_address} !== {1'b1, 3'd3}) begin
                    n_fail++; $display("FAIL bp_read: got %b required 1011", {read_en, read_address});
                end
            end
            if (c == 13) begin
                n_cmp++;
                if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 1'b1}) begin
                    n_fail++; $display("FAIL bp_read_rsp: got %b required 1011", {rsp_valid, rsp_id, rsp_data});
                end
            end
            @(posedge clk); #1;
            if (c == 5) write_rdy = 1'b1;
            if (c == 9) rsp_ready = 1'b1;
            if (c == 11) req_valid = 2'b00;
        end
        n_cmp++;
        if (we_cnt != 1) begin n_fail++; $display("FAIL bp_pulse_count: got %0d required 1", we_cnt); end
    endtask

    task automatic test_timeout();
        int last;
`ifdef ARB_TIMEOUT_EN
        last = TIMEOUT + 1;
`else
        last = 22;
`endif
        read_rdy = 1'b0; rsp_ready = 1'b1;
        set_req(1'b0, 1'b0, 3'd5, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL to_accept: got %b required 01", req_ready); end
        @(posedge clk); #1 req_valid = 2'b00;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
`ifdef ARB_TIMEOUT_EN
            n_cmp++;
            if (c < last && {read_en, rsp_valid} !== 2'b00) begin
                n_fail++; $display("FAIL to_wait c%0d: got %b required 00", c, {read_en, rsp_valid});
            end
            if (c == last && {read_en, rsp_valid, rsp_err, rsp_data} !== 4'b0110) begin
                n_fail++; $display("FAIL to_abort: got %b required 0110", {read_en, rsp_valid, rsp_err, rsp_data});
            end
`else
            n_cmp++;
            if (c <= 20 && {read_en, rsp_valid, rsp_err} !== 3'b000) begin
                n_fail++; $display("FAIL to_wait c%0d: got %b required 000", c, {read_en, rsp_valid, rsp_err});
            end
            if (c == 21 && read_en !== 1'b1) begin n_fail++; $display("FAIL to_late_enable: got %b required 1", read_en); end
            if (c == 22 && {rsp_valid, rsp_err} !== 2'b10) begin
                n_fail++; $display("FAIL to_late_rsp: got %b required 10", {rsp_valid, rsp_err});
            end
`endif
            @(posedge clk); #1;
            if (c == 20) read_rdy = 1'b1;
        end
        read_rdy = 1'b1;
        set_req(1'b0, 1'b0, 3'd5, 1'b0);
        @(negedge clk);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (read_en !== 1'b1) begin n_fail++; $display("FAIL to_retry_enable: got %b required 1", read_en); end
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_err} !== 2'b10) begin n_fail++; $display("FAIL to_retry_rsp: got %b required 10", {rsp_valid, rsp_err}); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_issue();
        int r;
        logic [1:0] drop;
        write_rdy = 1'b0; rsp_ready = 1'b1;
        set_req(1'b1, 1'b1, 3'd6, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b10) begin n_fail++; $display("FAIL mid_accept: got %b required 10", req_ready); end
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy, write_en, read_en,
             write_address, write_data, read_address, state_dbg} !== 21'd0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %b required 0", {req_ready, rsp_valid, rsp_id, rsp_data,
                rsp_err, busy, write_en, read_en, write_address, write_data, read_address, state_dbg});
        end
        @(posedge clk); #1 write_rdy = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        set_req(1'b0, 1'b1, 3'd7, 1'b0);
        set_req(1'b1, 1'b1, 3'd7, 1'b1);
        @(negedge clk);
        n_cmp++;
        if ({req_ready, rsp_valid} !== 3'b010) begin
            n_fail++; $display("FAIL mid_first_grant: got %b required 010", {req_ready, rsp_valid});
        end
        drop = 2'b01;
        r = 0;
        for (int cyc = 0; cyc < 20 && r < 2; cyc++) begin
            @(posedge clk); #1;
            req_valid = req_valid & ~drop;
            drop = 2'b00;
            @(negedge clk);
            if (req_ready !== 2'b00) begin
                n_cmp++;
                if (req_ready !== 2'b10) begin n_fail++; $display("FAIL mid_second_grant: got %b required 10", req_ready); end
                drop = req_ready;
            end
            if (rsp_valid) begin
                n_cmp++;
                if (rsp_id !== 2'(r)) begin n_fail++; $display("FAIL mid_rsp_order%0d: got %0d required %0d", r, rsp_id, r); end
                r++;
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (r != 2 || dut_mem[6] !== 1'b0) begin
            n_fail++; $display("FAIL mid_no_stale: got %0d rsps mem6=%b required 2 rsps mem6=0", r, dut_mem[6]);
        end
    endtask

    task automatic test_random();
        int accepts, resps, en_cnt, e, idx, wr_low, rd_low;
        logic [1:0] drop;
        logic       gid, cur_write, cur_data;
        logic [2:0] cur_addr;
        logic [3:0] exp;
        apply_reset();
        model_ptr = 0; ref_mem = dut_mem; exp_q.delete();
        accepts = 0; resps = 0; en_cnt = 0; wr_low = 0; rd_low = 0;
        cur_write = 1'b0; cur_addr = 3'd0; cur_data = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (accepts >= RAND_CMDS && exp_q.size() == 0 && req_valid == 2'b00) break;
            for (int k = 0; k < NREQ; k++) begin
                gid = k[0];
                if (!req_valid[gid] && accepts < RAND_CMDS && $urandom_range(0, 1) == 1)
                    set_req(gid, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
            @(negedge clk);
            drop = 2'b00;
            if (req_ready !== 2'b00) begin
                e = -1;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (model_ptr + k) % NREQ;
                    if (e < 0 && req_valid[idx[0]]) e = idx;
                end
                n_cmp++;
                if (e < 0 || req_ready !== (2'b01 << e)) begin
                    n_fail++; $display("FAIL rnd_grant: got %b required requester %0d", req_ready, e);
                end else begin
                    gid = e[0];
                    drop[gid] = 1'b1;
                    cur_write = req_write[gid]; cur_addr = r_addr[gid]; cur_data = req_data[gid];
                    if (cur_write) begin
                        ref_mem[cur_addr] = cur_data;
                        exp = {e[1:0], 2'b00};
                    end else begin
                        exp = {e[1:0], ref_mem[cur_addr], 1'b0};
                    end
                    exp_q.push_back(exp);
                    accepts++;
                end
            end
            if (write_en === 1'b1 || read_en === 1'b1) begin
                en_cnt++;
                n_cmp++;
                if (write_en !== cur_write || read_en !== !cur_write ||
                    (cur_write && {write_address, write_data} !== {cur_addr, cur_data}) ||
                    (!cur_write && read_address !== cur_addr)) begin
                    n_fail++; $display("FAIL rnd_enable: got we=%b re=%b wa=%0d wd=%b ra=%0d required write=%b addr=%0d data=%b",
                        write_en, read_en, write_address, write_data, read_address, cur_write, cur_addr, cur_data);
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_rsp: got id=%0d with no command outstanding required none", rsp_id);
                end else begin
                    exp = exp_q.pop_front();
                    if ({rsp_id, rsp_data, rsp_err} !== exp) begin
                        n_fail++; $display("FAIL rnd_rsp: got %b required %b", {rsp_id, rsp_data, rsp_err}, exp);
                    end
                    model_ptr = (int'(exp[3:2]) + 1) % NREQ;
                end
                resps++;
            end
            @(posedge clk); #1;
            req_valid = req_valid & ~drop;
            write_rdy = (wr_low >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
            read_rdy  = (rd_low >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
            wr_low    = write_rdy ? 0 : wr_low + 1;
            rd_low    = read_rdy ? 0 : rd_low + 1;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        n_cmp++;
        if (accepts < RAND_CMDS || exp_q.size() != 0 || resps != accepts || en_cnt != accepts) begin
            n_fail++; $display("FAIL rnd_drain: got accepts=%0d rsps=%0d enables=%0d left=%0d required %0d each, 0 left",
                accepts, resps, en_cnt, exp_q.size(), RAND_CMDS);
        end
        idle_inputs();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_write_read();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid_issue();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
